// File: rtl/motion_enc_pkg.sv
// Shared types for the multi-channel quadrature encoder front end:
// quadrature states, calibration FSM encoding and the step decoder.
package motion_enc_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic {CAL_IDLE = 1'b0, CAL_ARMED = 1'b1} cal_state_e;

  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL} step_e;

  // {A,B} prev/cur -> step; forward order is 00->01->11->10->00
  function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    s = STEP_NONE;
    if (prev != cur) begin
      if ((prev ^ cur) == 2'b11) s = STEP_ILL;
      else begin
        case (prev)
          QS_00:   s = (cur == QS_01) ? STEP_FWD : STEP_REV;
          QS_01:   s = (cur == QS_11) ? STEP_FWD : STEP_REV;
          QS_11:   s = (cur == QS_10) ? STEP_FWD : STEP_REV;
          default: s = (cur == QS_00) ? STEP_FWD : STEP_REV;
        endcase
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/motion_enc_ch.sv
// One encoder channel: sync, glitch filter, 4x decode, wrapping counter,
// index zero calibration and sticky illegal-transition flag.
module motion_enc_ch
  import motion_enc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_z,
  input  logic             ch_en,
  input  logic             dir_inv,
  input  logic             zero_calib,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             filt_a,
  output logic             filt_b,
  output logic             filt_z,
  output logic             zero_flag,
  output logic             enc_err
);

  localparam int FC_W = $clog2(FILT_LEN);

  // bit order {A,B,Z} throughout
  logic [2:0]           raw_s1, raw_s2, filt, filt_d;
  logic [2:0][FC_W-1:0] fcnt;
  logic                 cal_d;
  cal_state_e           state, state_nxt;
  step_e                step;
  logic                 z_rise, cal_rise, zero_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_s1 <= '0;
      raw_s2 <= '0;
      cal_d  <= 1'b0;
    end else begin
      raw_s1 <= {enc_a, enc_b, enc_z};
      raw_s2 <= raw_s1;
      cal_d  <= zero_calib;
    end
  end

  // a level is accepted only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
      filt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw_s2[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == FC_W'(FILT_LEN - 1)) begin
          filt[i] <= raw_s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 1'b1;
      end
    end
  end

  assign step     = quad_step(filt_d[2:1], filt[2:1]);
  assign z_rise   = filt[0] & ~filt_d[0];
  assign cal_rise = zero_calib & ~cal_d;
  assign zero_hit = ch_en && (state == CAL_ARMED) && z_rise;

  always_comb begin
    state_nxt = state;
    if (!ch_en) state_nxt = CAL_IDLE;
    else begin
      case (state)
        CAL_IDLE:  if (cal_rise) state_nxt = CAL_ARMED;
        CAL_ARMED: if (z_rise)   state_nxt = CAL_IDLE;
        default:   state_nxt = CAL_IDLE;
      endcase
    end
  end

  // prev tracks even while disabled so re-enable never sees a stale step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_d    <= '0;
      state     <= CAL_IDLE;
      cnt       <= '0;
      zero_flag <= 1'b0;
      enc_err   <= 1'b0;
    end else begin
      filt_d    <= filt;
      state     <= state_nxt;
      zero_flag <= zero_hit;
      if (zero_hit) cnt <= '0;
      else if (ch_en && step == STEP_FWD) cnt <= dir_inv ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
      else if (ch_en && step == STEP_REV) cnt <= dir_inv ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
      if (ch_en && step == STEP_ILL) enc_err <= 1'b1;
      else if (err_clr)              enc_err <= 1'b0;
    end
  end

  assign filt_a = filt[2];
  assign filt_b = filt[1];
  assign filt_z = filt[0];

endmodule

// File: rtl/motion_enc_multi_if.sv
// N-channel encoder front end: per-channel decoders plus a shared divider
// that snapshots all positions every SAMPLE_DIV cycles.
module motion_enc_multi_if
  import motion_enc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 4,
  parameter int SAMPLE_DIV = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enc_a_i,
  input  logic [NUM_CH-1:0]       enc_b_i,
  input  logic [NUM_CH-1:0]       enc_z_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH-1:0]       dir_inv_i,
  input  logic [NUM_CH-1:0]       zero_calib_i,
  input  logic [NUM_CH-1:0]       err_clr_i,
  output logic [NUM_CH-1:0]       enc_a_o,
  output logic [NUM_CH-1:0]       enc_b_o,
  output logic [NUM_CH-1:0]       enc_z_o,
  output logic [NUM_CH-1:0]       zero_flag_o,
  output logic                    data_out_en_o,
  output logic [NUM_CH*CNT_W-1:0] data_out_o,
  output logic [NUM_CH-1:0]       enc_err_o
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [DIV_W-1:0]             div_cnt;
  logic                         snap;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    motion_enc_ch #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enc_a      (enc_a_i[k]),
      .enc_b      (enc_b_i[k]),
      .enc_z      (enc_z_i[k]),
      .ch_en      (ch_en_i[k]),
      .dir_inv    (dir_inv_i[k]),
      .zero_calib (zero_calib_i[k]),
      .err_clr    (err_clr_i[k]),
      .cnt        (cnt[k]),
      .filt_a     (enc_a_o[k]),
      .filt_b     (enc_b_o[k]),
      .filt_z     (enc_z_o[k]),
      .zero_flag  (zero_flag_o[k]),
      .enc_err    (enc_err_o[k])
    );
  end

  assign snap = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  // strobe and data are registered together so they appear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt       <= '0;
      data_out_en_o <= 1'b0;
      data_out_o    <= '0;
    end else begin
      div_cnt       <= snap ? '0 : div_cnt + 1'b1;
      data_out_en_o <= snap;
      if (snap) data_out_o <= cnt;
    end
  end

endmodule
